// File: rtl/mdu_issue_ctrl_if.sv
// ============================================================================
// Module   : mdu_issue_ctrl_if
// Brief    : E-stage <-> MDU issue controller handshake bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mdu_issue_ctrl_if;
  logic       op_valid;
  logic [3:0] op;
  logic       int_req;
  logic       mdu_start;
  logic [2:0] mdu_op;
  logic       hi_we;
  logic       lo_we;
  logic       commit;
  logic       busy;
  logic       stall;
  logic [1:0] rd_sel;

  modport master (
    output op_valid, op, int_req,
    input  mdu_start, mdu_op, hi_we, lo_we, commit, busy, stall, rd_sel
  );

  modport slave (
    input  op_valid, op, int_req,
    output mdu_start, mdu_op, hi_we, lo_we, commit, busy, stall, rd_sel
  );
endinterface

`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
// ============================================================================
// Module   : mdu_issue_ctrl
// Brief    : MDU issue/sequencing: start pulses, latency countdown, HI/LO
//            write enables, commit strobe and hazard stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  mdu_issue_ctrl_if.slave  bus
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;
  localparam logic [3:0] c_mul_lat = 4'(MUL_LAT);
  localparam logic [3:0] c_div_lat = 4'(DIV_LAT);

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic w_is_md;
  logic w_is_start;
  logic w_busy;
  logic w_accept;
  logic w_start;

  always_comb begin
    w_is_md    = (bus.op >= 4'd1) && (bus.op <= 4'd8);
    w_is_start = (bus.op >= 4'd1) && (bus.op <= 4'd4);
    w_busy     = (state_q == c_st_run);
    w_accept   = bus.op_valid && !bus.int_req && !w_busy && w_is_md;
    w_start    = w_accept && w_is_start;

    bus.mdu_start = w_start;
    bus.mdu_op    = 3'b000;
    if (w_start) begin
      case (bus.op)
        4'd1:    bus.mdu_op = 3'b001;
        4'd2:    bus.mdu_op = 3'b000;
        4'd3:    bus.mdu_op = 3'b011;
        4'd4:    bus.mdu_op = 3'b010;
        default: bus.mdu_op = 3'b000;
      endcase
    end

    bus.hi_we  = w_accept && (bus.op == 4'd5);
    bus.lo_we  = w_accept && (bus.op == 4'd6);
    bus.rd_sel = 2'b00;
    if (w_accept && (bus.op == 4'd7)) bus.rd_sel = 2'b01;
    if (w_accept && (bus.op == 4'd8)) bus.rd_sel = 2'b10;

    // Commit lands in the final busy cycle, so a waiting op issues the next cycle.
    bus.commit = w_busy && (cnt_q == 4'd1);
    bus.busy   = w_busy;
    bus.stall  = bus.op_valid && w_is_md && w_busy;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (w_busy) begin
      if (cnt_q == 4'd1) begin
        state_d = c_st_idle;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (w_start) begin
      state_d = c_st_run;
      cnt_d   = (bus.op <= 4'd2) ? c_mul_lat : c_div_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_st_idle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
// ============================================================================
// Module   : tb_mdu_issue_ctrl
// Brief    : Directed scoreboard bench for mdu_issue_ctrl (MUL_LAT=5, DIV_LAT=10).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_issue_ctrl;

  logic clk;
  logic reset;

  mdu_issue_ctrl_if bus ();

  mdu_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        cnt_chk;
    logic [3:0]  cnt;
    logic [10:0] out;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // {mdu_start, mdu_op[2:0], hi_we, lo_we, commit, busy, stall, rd_sel[1:0]}
  function automatic logic [10:0] ev(input logic st, input logic [2:0] mop,
                                     input logic hi, input logic lo, input logic com,
                                     input logic bsy, input logic stl, input logic [1:0] rd);
    return {st, mop, hi, lo, com, bsy, stl, rd};
  endfunction

  localparam logic [10:0] c_z  = 11'b0;
  localparam logic [10:0] c_b  = 11'b000_0_0_0_1_0_00;
  localparam logic [10:0] c_bc = 11'b000_0_0_1_1_0_00;

  task automatic step(input logic v, input logic [3:0] o, input logic ir, input logic rs,
                      input logic chk, input logic cchk, input logic [3:0] cnt,
                      input logic [10:0] e, input string nm);
    exp_t x;
    bus.op_valid = v;
    bus.op       = o;
    bus.int_req  = ir;
    reset        = rs;
    x.chk = chk; x.cnt_chk = cchk; x.cnt = cnt; x.out = e; x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_step(input logic v, input logic [3:0] o, input logic ir,
                          input logic [10:0] e, input string nm);
    step(v, o, ir, 1'b0, 1'b1, 1'b0, 4'd0, e, nm);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t x;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        act = {bus.mdu_start, bus.mdu_op, bus.hi_we, bus.lo_we, bus.commit,
               bus.busy, bus.stall, bus.rd_sel};
        if (x.chk) begin
          checks++;
          if (act !== x.out) begin
            errors++;
            $display("FAIL %s outputs got %b expected %b", x.name, act, x.out);
          end
        end
        if (x.cnt_chk) begin
          checks++;
          if (dut.cnt_q !== x.cnt) begin
            errors++;
            $display("FAIL %s cnt got %0d expected %0d", x.name, dut.cnt_q, x.cnt);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = 4'd0;
    bus.int_req  = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 1, 0, 0, 0, c_z, "rst0");
    step(0, 0, 0, 1, 0, 0, 0, c_z, "rst1");
    step(0, 0, 0, 0, 1, 1, 4'd0, c_z, "reset_state");

    // MULT: busy 5 cycles, commit in the 5th
    chk_step(1, 4'd1, 0, ev(1, 3'b001, 0, 0, 0, 0, 0, 2'b00), "mult_start");
    for (int i = 0; i < 4; i++) chk_step(0, 4'd0, 0, c_b, "mult_busy");
    chk_step(0, 4'd0, 0, c_bc, "mult_commit");
    chk_step(0, 4'd0, 0, c_z, "mult_done");

    // DIVU then MFLO held: stalls through commit, reads LO after
    chk_step(1, 4'd4, 0, ev(1, 3'b010, 0, 0, 0, 0, 0, 2'b00), "divu_start");
    for (int i = 0; i < 9; i++) chk_step(1, 4'd8, 0, ev(0, 0, 0, 0, 0, 1, 1, 2'b00), "mflo_stall");
    chk_step(1, 4'd8, 0, ev(0, 0, 0, 0, 1, 1, 1, 2'b00), "mflo_stall_commit");
    chk_step(1, 4'd8, 0, ev(0, 0, 0, 0, 0, 0, 0, 2'b10), "mflo_read");
    chk_step(0, 4'd0, 0, c_z, "divu_done");

    // Move-to/move-from with and without interrupt
    chk_step(1, 4'd5, 1, c_z, "mthi_int");
    chk_step(1, 4'd5, 0, ev(0, 0, 1, 0, 0, 0, 0, 2'b00), "mthi");
    chk_step(1, 4'd6, 0, ev(0, 0, 0, 1, 0, 0, 0, 2'b00), "mtlo");
    chk_step(1, 4'd7, 0, ev(0, 0, 0, 0, 0, 0, 0, 2'b01), "mfhi");
    chk_step(1, 4'd7, 1, c_z, "mfhi_int");
    chk_step(0, 4'd8, 0, c_z, "mflo_invalid");
    chk_step(1, 4'd1, 1, c_z, "mult_int_no_start");

    // Interrupt during RUN does not cancel the operation
    chk_step(1, 4'd1, 0, ev(1, 3'b001, 0, 0, 0, 0, 0, 2'b00), "mult2_start");
    chk_step(0, 4'd0, 0, c_b, "mult2_busy1");
    chk_step(0, 4'd0, 1, c_b, "mult2_int_busy");
    chk_step(0, 4'd0, 0, c_b, "mult2_busy3");
    chk_step(0, 4'd0, 0, c_b, "mult2_busy4");
    chk_step(0, 4'd0, 0, c_bc, "mult2_commit");
    chk_step(0, 4'd0, 0, c_z, "mult2_done");

    // DIV aborted by reset mid-RUN
    chk_step(1, 4'd3, 0, ev(1, 3'b011, 0, 0, 0, 0, 0, 2'b00), "div_start");
    for (int i = 0; i < 3; i++) chk_step(0, 4'd0, 0, c_b, "div_busy");
    step(0, 4'd0, 0, 1, 1, 1, 4'd7, c_b, "div_pre_reset");
    step(0, 4'd0, 0, 0, 1, 1, 4'd0, c_z, "div_abort");
    chk_step(1, 4'd0, 0, c_z, "nop_after_abort");
    for (int i = 0; i < 10; i++) chk_step(0, 4'd0, 0, c_z, "no_commit_after_abort");

    // Non-MD ops while busy; MULTU at the commit cycle
    chk_step(1, 4'd1, 0, ev(1, 3'b001, 0, 0, 0, 0, 0, 2'b00), "mult3_start");
    chk_step(1, 4'd0, 0, c_b, "nop_busy");
    chk_step(1, 4'd12, 0, c_b, "op12_busy");
    chk_step(1, 4'd5, 0, ev(0, 0, 0, 0, 0, 1, 1, 2'b00), "mthi_busy_stall");
    chk_step(0, 4'd0, 0, c_b, "mult3_busy4");
    chk_step(1, 4'd2, 0, ev(0, 0, 0, 0, 1, 1, 1, 2'b00), "multu_commit_stall");
    chk_step(1, 4'd2, 0, ev(1, 3'b000, 0, 0, 0, 0, 0, 2'b00), "multu_start");
    for (int i = 0; i < 4; i++) chk_step(0, 4'd0, 0, c_b, "multu_busy");
    chk_step(0, 4'd0, 0, c_bc, "multu_commit");
    chk_step(0, 4'd0, 0, c_z, "multu_done");

    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain queue left %0d expected 0", exp_q.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue and sequencing controller for the multiply/divide unit in the E stage of the pipelined CPU.
- Decodes the E-stage MDU operation and issues single-cycle start pulses with the datapath op code.
- Owns the latency countdown and the busy state, and generates HI/LO write enables and the commit strobe.
- Drives the hazard-unit stall for MDU-class instructions and blocks issue while an interrupt request is pending.

Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (must be >= 1)
- DIV_LAT, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  E-stage instruction is valid (not a bubble)
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 are treated as NOP
- int_req  in  1  interrupt/exception taken this cycle; suppresses issue
- mdu_start  out  1  one-cycle start pulse to the MDU datapath
- mdu_op  out  3  000 MULU, 001 MUL, 010 DIVU, 011 DIV; valid only while mdu_start=1, 000 otherwise
- hi_we  out  1  write rs to HI (MTHI)
- lo_we  out  1  write rs to LO (MTLO)
- commit  out  1  one-cycle strobe: latch the MDU temporary result into HI/LO
- busy  out  1  operation in flight
- stall  out  1  to hazard unit: freeze F/D/E and bubble M
- rd_sel  out  2  E-stage read mux: 00 none, 01 HI, 10 LO

Behaviour:
- Op classes: md = ops 1-8; start-class = ops 1-4; nop = op 0 or 9-15.
- State machine: IDLE, RUN. Counter cnt is 4 bits wide; its sizing covers max(MUL_LAT, DIV_LAT) <= 15.
- Reset (synchronous): state=IDLE, cnt=0. All outputs are 0 in the cycle after reset is sampled.
- Reset mid-RUN aborts the operation: no commit is issued and HI/LO are unchanged.
- accept = op_valid & !int_req & !busy & md-class op.
- IDLE, accept of a start-class op:
  - mdu_start=1 combinationally in the same cycle, with mdu_op mapped MULT->001, MULTU->000, DIV->011, DIVU->010.
  - Next edge: state=RUN, cnt=MUL_LAT for MULT/MULTU, DIV_LAT for DIV/DIVU.
- RUN:
  - busy=1.
  - Each cycle: if cnt==1, commit=1 and next state=IDLE, cnt=0; otherwise cnt=cnt-1.
  - busy is therefore high for exactly LAT cycles, and commit fires in the last of them.
- IDLE, accept of MTHI or MTLO: hi_we=1 or lo_we=1 combinationally for one cycle; no state change.
- IDLE, accept of MFHI or MFLO: rd_sel=01 or 10 combinationally; no state change.
- rd_sel=00 whenever op_valid=0, the op is not MFHI/MFLO, busy=1, or int_req=1.
- stall = op_valid & md-class & busy. stall never asserts for nop-class ops or when op_valid=0. An MDU-class op presented while busy (including the commit cycle) stalls, and is accepted in the first cycle busy is low.
- int_req=1 suppresses that cycle's mdu_start, hi_we, lo_we and rd_sel; no state change and no stall.
- int_req does not cancel an operation already in RUN; it completes and commits (MIPS semantics: an issued multiply/divide is not rolled back).
- mdu_start, hi_we, lo_we and commit are mutually exclusive by construction.
- Divide by zero: no special handling; sequencing and commit timing are identical to any other divide.
- Back-to-back ops: a second start-class op presented in the cycle after commit is accepted with zero bubbles beyond the stall cycles.

Test Plan:
- Reset, then op_valid=1, op=1 (MULT) at cycle 0 -> mdu_start=1 and mdu_op=001 at cycle 0; busy=1 cycles 1-5; commit=1 at cycle 5 only; busy=0 at cycle 6.
- DIVU issued at cycle 0, then MFLO held from cycle 1 -> stall=1 cycles 1-10 with rd_sel=00; at cycle 11 stall=0 and rd_sel=10.
- op=5 (MTHI) with int_req=1 -> hi_we=0, stall=0; the same op with int_req=0 on the next cycle -> hi_we=1 for one cycle.
- MULT issued, int_req=1 at cycle 2 -> busy is unaffected; commit=1 at cycle 5.
- DIV issued, reset asserted at cycle 4 -> busy=0 and cnt=0 from cycle 5; no commit is observed; op=0 (NOP) presented afterwards -> stall=0.
- NOP and op=12 presented while busy -> stall=0 and all strobes 0; MULTU presented at the commit cycle -> stalls one cycle, then mdu_start=1 with mdu_op=000.
